display_timing_480p: RTL and testbench
======================================

# display_timing_480p

Display timing generator for 640x480 @ 60 Hz VGA, clocked by the 25 MHz pixel clock produced by the board clock divider. It produces horizontal/vertical pixel coordinates, active-low sync pulses, a data-enable, and per-line/per-frame strobes. Downstream pixel generators and the VGA output pins consume these signals. All outputs are registered and mutually aligned.

## Interface
Parameters:
- CORDW, 10, width of the coordinate outputs
- H_RES, 640, active pixels per line
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 96, horizontal sync width in pixels
- H_BP, 48, horizontal back porch in pixels
- V_RES, 480, active lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BP, 33, vertical back porch in lines

Ports:
- clk_pix, input, 1, pixel clock (25 MHz). The only clock.
- rst, input, 1, reset. Asynchronous, active-high.
- sx, output, CORDW, horizontal position, 0..H_TOT-1
- sy, output, CORDW, vertical position, 0..V_TOT-1
- hsync, output, 1, horizontal sync, active low
- vsync, output, 1, vertical sync, active low
- de, output, 1, data enable. High in the active area.
- line, output, 1, one-cycle strobe at sx==0 on every line
- frame, output, 1, one-cycle strobe at sx==0 && sy==0
- frame_cnt, output, 8, frame counter. Present only with DISPLAY_FRAME_CNT_EN.

## Operation
- Derived constants:
  - H_TOT = H_RES+H_FP+H_SYNC+H_BP (800)
  - V_TOT = V_RES+V_FP+V_SYNC+V_BP (525)
  - HS_STA = H_RES+H_FP (656), HS_END = HS_STA+H_SYNC-1 (751)
  - VS_STA = V_RES+V_FP (490), VS_END = VS_STA+V_SYNC-1 (491)
- Horizontal counter:
  - sx increments by 1 every clk_pix.
  - At sx==H_TOT-1 it wraps to 0, and sy advances.
- Vertical counter:
  - sy increments only when sx wraps.
  - At sy==V_TOT-1 together with sx==H_TOT-1, sy wraps to 0.
- Decode is computed from the next-state counters and registered, so each decoded output describes the sx/sy value shown in the same cycle:
  - hsync = 0 iff HS_STA ≤ sx ≤ HS_END
  - vsync = 0 iff VS_STA ≤ sy ≤ VS_END
  - de = 1 iff sx < H_RES && sy < V_RES
  - line = 1 iff sx == 0
  - frame = 1 iff sx == 0 && sy == 0
- The vsync edge coincides with the sx==0 cycle of lines VS_STA and VS_END+1.
- Arithmetic:
  - All compares are unsigned.
  - CORDW must hold V_TOT-1 and H_TOT-1; with defaults the maximum is 799 in 10 bits.
  - No counter ever exceeds its total-minus-one.
- There is no state machine beyond the two chained counters. Counter state fully determines all outputs.

## Timing
- Reset values, applied while rst is high:
  - sx = H_TOT-1 (799), sy = V_TOT-1 (524)
  - hsync = 1, vsync = 1
  - de = 0, line = 0, frame = 0
  - frame_cnt = 0
- Reset is asynchronous: outputs take their reset values immediately, with no clock edge needed.
- Reset asserted mid-frame abandons the frame at once. Nothing from the old frame persists.
- First clk_pix rising edge after rst deasserts:
  - sx = 0, sy = 0, de = 1, line = 1, frame = 1
- Latency: one cycle from counter advance to output. Outputs have no combinational path from inputs.
- Line period is 800 cycles; frame period is 420000 cycles.
- Simultaneous wrap: at (799, 524) both counters wrap on the same edge to (0, 0).

## Configuration
- Macro: DISPLAY_FRAME_CNT_EN.
- Defined:
  - frame_cnt port exists.
  - It increments on the same edge that raises frame, i.e. on entry to (0, 0).
  - It wraps 255 → 0.
  - Reset sets it to 0, so the first frame after reset reads 1.
- Undefined:
  - Port and register are absent.
  - All other behaviour is identical.

## Test plan
- Reset release:
  - Hold rst for 3 cycles, then release.
  - During reset: sx = 799, sy = 524, hsync = vsync = 1, de = 0.
  - First edge after release: sx = 0, sy = 0, frame = 1, line = 1, de = 1.
- Horizontal line:
  - Run one line.
  - de = 1 for sx 0..639.
  - hsync = 0 for exactly 96 cycles, sx 656..751.
  - line pulses exactly once per 800 cycles.
- Full frame:
  - Run 2 frames.
  - vsync = 0 only on sy 490 and 491, i.e. 1600 cycles.
  - frame pulses are exactly 420000 cycles apart.
  - de-high count per frame is 307200.
- Wrap boundary:
  - At sx = 799, sy = 524, the next edge gives sx = 0, sy = 0, frame = 1.
  - At sx = 799, sy = 10, the next edge gives sx = 0, sy = 11, frame = 0.
- Asynchronous reset mid-frame:
  - Assert rst between clock edges at sx = 300, sy = 200.
  - Outputs take reset values before the next edge.
  - After release, the frame restarts at (0, 0).
- With DISPLAY_FRAME_CNT_EN:
  - Run 257 frames from reset.
  - frame_cnt reads 1 in the first frame.
  - It reads 255 in frame 255 and 0 in frame 256.

Source files
------------

// File: rtl/display_timing_480p_if.sv
// Video timing bundle: coordinates, syncs, data-enable and line/frame strobes.
// frame_cnt exists only when DISPLAY_FRAME_CNT_EN is defined.
interface display_timing_480p_if #(
  parameter int CORDW = 10
);
  logic [CORDW-1:0] sx;
  logic [CORDW-1:0] sy;
  logic             hsync;
  logic             vsync;
  logic             de;
  logic             line;
  logic             frame;
`ifdef DISPLAY_FRAME_CNT_EN
  logic [7:0]       frame_cnt;
`endif

  // All signals are registered in the timing generator; there is no handshake,
  // the sink simply samples every pixel clock.
  modport master (
    output sx, sy, hsync, vsync, de, line, frame
`ifdef DISPLAY_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    input sx, sy, hsync, vsync, de, line, frame
`ifdef DISPLAY_FRAME_CNT_EN
    , input frame_cnt
`endif
  );
endinterface

// File: rtl/display_timing_480p.sv
// 640x480@60 display timing generator on the 25 MHz pixel clock.
// Optional 8-bit frame counter enabled by DISPLAY_FRAME_CNT_EN.
module display_timing_480p #(
  parameter int CORDW  = 10,
  parameter int H_RES  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_RES  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic                    clk_pix,
  input  logic                    rst,
  display_timing_480p_if.master   vid
);

  localparam int H_TOT  = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_RES + V_FP + V_SYNC + V_BP;
  localparam int HS_STA = H_RES + H_FP;
  localparam int HS_END = HS_STA + H_SYNC - 1;
  localparam int VS_STA = V_RES + V_FP;
  localparam int VS_END = VS_STA + V_SYNC - 1;

  localparam logic [CORDW-1:0] H_MAX    = CORDW'(H_TOT - 1);
  localparam logic [CORDW-1:0] V_MAX    = CORDW'(V_TOT - 1);
  localparam logic [CORDW-1:0] H_RES_C  = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_RES_C  = CORDW'(V_RES);
  localparam logic [CORDW-1:0] HS_STA_C = CORDW'(HS_STA);
  localparam logic [CORDW-1:0] HS_END_C = CORDW'(HS_END);
  localparam logic [CORDW-1:0] VS_STA_C = CORDW'(VS_STA);
  localparam logic [CORDW-1:0] VS_END_C = CORDW'(VS_END);

  logic [CORDW-1:0] sx_q, sx_d;
  logic [CORDW-1:0] sy_q, sy_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             de_q, de_d;
  logic             line_q, line_d;
  logic             frame_q, frame_d;
`ifdef DISPLAY_FRAME_CNT_EN
  logic [7:0]       frame_cnt_q, frame_cnt_d;
`endif

  // Decode uses the next-state counters so the registered flags line up
  // with the registered coordinates in the same cycle.
  always_comb begin
    sx_d = sx_q + CORDW'(1);
    sy_d = sy_q;
    if (sx_q == H_MAX) begin
      sx_d = '0;
      sy_d = (sy_q == V_MAX) ? '0 : sy_q + CORDW'(1);
    end
    hsync_d = !((sx_d >= HS_STA_C) && (sx_d <= HS_END_C));
    vsync_d = !((sy_d >= VS_STA_C) && (sy_d <= VS_END_C));
    de_d    = (sx_d < H_RES_C) && (sy_d < V_RES_C);
    line_d  = (sx_d == '0);
    frame_d = (sx_d == '0) && (sy_d == '0);
  end

`ifdef DISPLAY_FRAME_CNT_EN
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_d) frame_cnt_d = frame_cnt_q + 8'd1;
  end
`endif

  // Reset parks the counters on the last pixel so the first edge lands on (0,0).
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      sx_q        <= H_MAX;
      sy_q        <= V_MAX;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      de_q        <= 1'b0;
      line_q      <= 1'b0;
      frame_q     <= 1'b0;
`ifdef DISPLAY_FRAME_CNT_EN
      frame_cnt_q <= 8'd0;
`endif
    end else begin
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      de_q        <= de_d;
      line_q      <= line_d;
      frame_q     <= frame_d;
`ifdef DISPLAY_FRAME_CNT_EN
      frame_cnt_q <= frame_cnt_d;
`endif
    end
  end

  assign vid.sx    = sx_q;
  assign vid.sy    = sy_q;
  assign vid.hsync = hsync_q;
  assign vid.vsync = vsync_q;
  assign vid.de    = de_q;
  assign vid.line  = line_q;
  assign vid.frame = frame_q;
`ifdef DISPLAY_FRAME_CNT_EN
  assign vid.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_display_timing_480p.sv
// Bench for display_timing_480p: a reduced-geometry instance for whole-frame
// behaviour and a default 640x480 instance for reset and line timing.
module tb_display_timing_480p;

  localparam int S_H_RES = 12, S_H_FP = 2, S_H_SYNC = 3, S_H_BP = 3;
  localparam int S_V_RES = 6,  S_V_FP = 2, S_V_SYNC = 2, S_V_BP = 2;
  localparam int S_H_TOT = S_H_RES + S_H_FP + S_H_SYNC + S_H_BP;   // 20
  localparam int S_V_TOT = S_V_RES + S_V_FP + S_V_SYNC + S_V_BP;   // 12
  localparam int S_F_TOT = S_H_TOT * S_V_TOT;                      // 240
  localparam int S_HS_STA = S_H_RES + S_H_FP;                      // 14
  localparam int S_HS_END = S_HS_STA + S_H_SYNC - 1;               // 16
  localparam int S_VS_STA = S_V_RES + S_V_FP;                      // 8
  localparam int S_VS_END = S_VS_STA + S_V_SYNC - 1;               // 9
  localparam int W = 33;

  // clock / reset
  logic clk_pix = 1'b0;
  logic rst;
  always #5 clk_pix = ~clk_pix;

  display_timing_480p_if #(.CORDW(10)) s_if ();
  display_timing_480p_if #(.CORDW(10)) d_if ();

  display_timing_480p #(
    .CORDW(10), .H_RES(S_H_RES), .H_FP(S_H_FP), .H_SYNC(S_H_SYNC), .H_BP(S_H_BP),
    .V_RES(S_V_RES), .V_FP(S_V_FP), .V_SYNC(S_V_SYNC), .V_BP(S_V_BP)
  ) u_small (.clk_pix(clk_pix), .rst(rst), .vid(s_if));

  display_timing_480p u_dflt (.clk_pix(clk_pix), .rst(rst), .vid(d_if));

  int checks = 0;
  int errors = 0;
  int cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] s_fc();
`ifdef DISPLAY_FRAME_CNT_EN
    return s_if.frame_cnt;
`else
    return 8'd0;
`endif
  endfunction

  function automatic logic [W-1:0] act_vec();
    return {s_if.sx, s_if.sy, s_if.hsync, s_if.vsync, s_if.de, s_if.line, s_if.frame, s_fc()};
  endfunction

  // Reference: position derived from the cycle index since reset release.
  function automatic logic [W-1:0] exp_vec(input int k);
    int x, y, f;
    logic hs, vs, de, ln, fr;
    logic [7:0] fc;
    x  = k % S_H_TOT;
    y  = (k / S_H_TOT) % S_V_TOT;
    f  = k / S_F_TOT;
    hs = !(x >= S_HS_STA && x <= S_HS_END);
    vs = !(y >= S_VS_STA && y <= S_VS_END);
    de = (x < S_H_RES) && (y < S_V_RES);
    ln = (x == 0);
    fr = (x == 0) && (y == 0);
`ifdef DISPLAY_FRAME_CNT_EN
    fc = 8'((f + 1) % 256);
`else
    fc = 8'd0;
`endif
    return {10'(x), 10'(y), hs, vs, de, ln, fr, fc};
  endfunction

  // scoreboard
  logic [W-1:0] exp_q[$];
  int k_sb = 0;

  always @(posedge rst) begin
    exp_q.delete();
    k_sb = 0;
  end

  always @(posedge clk_pix) begin
    if (rst === 1'b0) begin
      exp_q.push_back(exp_vec(k_sb));
      k_sb++;
    end
  end

  always @(negedge clk_pix) begin
    logic [W-1:0] e;
    if (rst === 1'b0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("scoreboard", act_vec(), e);
    end
  end

  // boundary vectors for the small instance
  typedef struct {
    int         cyc;
    logic [9:0] sx;
    logic [9:0] sy;
    logic       hs, vs, de, ln, fr;
  } vec_t;
  vec_t tbl[20];

  // statistics gathered while stepping
  bit stats_on = 0;
  int d_de = 0, d_hs = 0, d_line = 0, d_hs_first = -1, d_hs_last = -1;
  int s_vs = 0, s_de = 0, s_line = 0, s_hs = 0;
  int fpos[$];

  task automatic step();
    @(posedge clk_pix);
    #1;
    cyc++;
    if (stats_on) begin
      if (cyc < 800) begin
        d_de   += int'(d_if.de);
        d_line += int'(d_if.line);
        if (!d_if.hsync) begin
          d_hs++;
          if (d_hs_first < 0) d_hs_first = int'(d_if.sx);
          d_hs_last = int'(d_if.sx);
        end
      end
      if (cyc < 2 * S_F_TOT) begin
        s_vs   += int'(!s_if.vsync);
        s_hs   += int'(!s_if.hsync);
        s_de   += int'(s_if.de);
        s_line += int'(s_if.line);
      end
      if (cyc <= 2 * S_F_TOT && s_if.frame) fpos.push_back(cyc);
    end
  endtask

  int target;

  initial begin
    tbl[0]  = '{0,   10'd0,  10'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{11,  10'd11, 10'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{12,  10'd12, 10'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{13,  10'd13, 10'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{14,  10'd14, 10'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{16,  10'd16, 10'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{17,  10'd17, 10'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{19,  10'd19, 10'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{20,  10'd0,  10'd1,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{39,  10'd19, 10'd1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{40,  10'd0,  10'd2,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{119, 10'd19, 10'd5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{120, 10'd0,  10'd6,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{159, 10'd19, 10'd7,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{160, 10'd0,  10'd8,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{199, 10'd19, 10'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{200, 10'd0,  10'd10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[17] = '{214, 10'd14, 10'd10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{239, 10'd19, 10'd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[19] = '{240, 10'd0,  10'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // reset held for three cycles
    rst = 1'b1;
    cyc = -1;
    repeat (3) @(posedge clk_pix);
    #1;
    check("rst_small", {s_if.sx, s_if.sy, s_if.hsync, s_if.vsync, s_if.de, s_if.line, s_if.frame},
          {10'd19, 10'd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    check("rst_dflt", {d_if.sx, d_if.sy, d_if.hsync, d_if.vsync, d_if.de, d_if.line, d_if.frame},
          {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
`ifdef DISPLAY_FRAME_CNT_EN
    check("rst_frame_cnt", s_if.frame_cnt, 8'd0);
`endif
    @(negedge clk_pix);
    rst = 1'b0;
    cyc = -1;
    stats_on = 1;

    step();
    check("first_edge_dflt", {d_if.sx, d_if.sy, d_if.de, d_if.line, d_if.frame},
          {10'd0, 10'd0, 1'b1, 1'b1, 1'b1});
`ifdef DISPLAY_FRAME_CNT_EN
    check("frame_cnt_first", s_if.frame_cnt, 8'd1);
`endif

    foreach (tbl[i]) begin
      while (cyc < tbl[i].cyc) step();
      check($sformatf("vec%0d", i),
            {s_if.sx, s_if.sy, s_if.hsync, s_if.vsync, s_if.de, s_if.line, s_if.frame},
            {tbl[i].sx, tbl[i].sy, tbl[i].hs, tbl[i].vs, tbl[i].de, tbl[i].ln, tbl[i].fr});
    end

    while (cyc < 800) step();
    stats_on = 0;
    check("dflt_de_per_line", d_de, 640);
    check("dflt_hsync_low_cycles", d_hs, 96);
    check("dflt_hsync_first_sx", d_hs_first, 656);
    check("dflt_hsync_last_sx", d_hs_last, 751);
    check("dflt_line_pulses", d_line, 1);
    check("dflt_second_line", {d_if.sx, d_if.sy, d_if.line, d_if.frame},
          {10'd0, 10'd1, 1'b1, 1'b0});
    check("small_vsync_low_2frames", s_vs, 2 * S_V_SYNC * S_H_TOT);
    check("small_hsync_low_2frames", s_hs, 2 * S_H_SYNC * S_V_TOT);
    check("small_de_2frames", s_de, 2 * S_H_RES * S_V_RES);
    check("small_line_2frames", s_line, 2 * S_V_TOT);
    check("small_frame_pulses", fpos.size(), 3);
    if (fpos.size() == 3) begin
      check("frame_spacing_a", fpos[1] - fpos[0], S_F_TOT);
      check("frame_spacing_b", fpos[2] - fpos[1], S_F_TOT);
    end

`ifdef DISPLAY_FRAME_CNT_EN
    while (cyc < 254 * S_F_TOT + 7) step();
    check("frame_cnt_255", s_if.frame_cnt, 8'd255);
    while (cyc < 255 * S_F_TOT + 7) step();
    check("frame_cnt_wrap", s_if.frame_cnt, 8'd0);
    while (cyc < 256 * S_F_TOT + 7) step();
    check("frame_cnt_257", s_if.frame_cnt, 8'd1);
`endif

    // asynchronous reset between edges at (5,3)
    target = (cyc / S_F_TOT + 1) * S_F_TOT + 3 * S_H_TOT + 5;
    while (cyc < target) step();
    check("pre_async_pos", {s_if.sx, s_if.sy}, {10'd5, 10'd3});
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_small", {s_if.sx, s_if.sy, s_if.hsync, s_if.vsync, s_if.de, s_if.line, s_if.frame},
          {10'd19, 10'd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    check("async_rst_dflt", {d_if.sx, d_if.sy, d_if.hsync, d_if.vsync, d_if.de},
          {10'd799, 10'd524, 1'b1, 1'b1, 1'b0});
`ifdef DISPLAY_FRAME_CNT_EN
    check("async_rst_frame_cnt", s_if.frame_cnt, 8'd0);
`endif
    @(negedge clk_pix);
    @(negedge clk_pix);
    rst = 1'b0;
    cyc = -1;
    step();
    check("restart_small", {s_if.sx, s_if.sy, s_if.de, s_if.line, s_if.frame},
          {10'd0, 10'd0, 1'b1, 1'b1, 1'b1});
    check("restart_dflt", {d_if.sx, d_if.sy, d_if.frame}, {10'd0, 10'd0, 1'b1});
`ifdef DISPLAY_FRAME_CNT_EN
    check("restart_frame_cnt", s_if.frame_cnt, 8'd1);
`endif
    repeat (60) step();
    @(negedge clk_pix);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
